timer_counter_n: RTL and testbench

TIMER_COUNTER_N -- requirements
Module: timer_counter_n

---
 rtl/timer_counter_n.sv | 114 +++++++++++
 tb/tb_timer_counter_n.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter_n.sv
`default_nettype none
// ============================================================================
// Module   : timer_counter_n
// Purpose  : Up/down timer counter with a load strobe, a reload shadow and
//            three sticky flags: overflow, underflow and compare match.
//            A count step ("tick") happens only when enable and clk_ena are
//            both high. A load takes priority over a tick.
// Ports    : clk, rst_n          - clock; asynchronous active-low reset
//            clk_ena            - tick qualifier from the prescaler
//            start_value        - value loaded into the counter and shadow
//            up_down            - 1 = count up, 0 = count down
//            load, enable       - load strobe, count enable
//            auto_reload        - on wrap, 1 = reload shadow, 0 = free-run
//            compare_value      - compare-match target
//            clr_overflow/underflow/compare - sticky flag clears
//            count              - registered counter value
//            overflow, underflow, compare_match - sticky flags
// Revision : 1.0 - initial release
// ============================================================================
module timer_counter_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_ena,
  input  logic [WIDTH-1:0] start_value,
  input  logic             up_down,
  input  logic             load,
  input  logic             enable,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] compare_value,
  input  logic             clr_overflow,
  input  logic             clr_underflow,
  input  logic             clr_compare,
  output logic [WIDTH-1:0] count,
  output logic             overflow,
  output logic             underflow,
  output logic             compare_match
);

  localparam logic [WIDTH-1:0] c_max  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_zero = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_shadow;
  logic             r_overflow;
  logic             r_underflow;
  logic             r_compare;

  logic [WIDTH-1:0] w_count_next;
  logic             w_tick;
  logic             w_ov_set;
  logic             w_un_set;
  logic             w_cm_set;

  // A load suppresses the tick on the same edge.
  assign w_tick = enable & clk_ena & ~load;

  always_comb begin
    w_count_next = r_count;
    w_ov_set     = 1'b0;
    w_un_set     = 1'b0;
    if (load) begin
      w_count_next = start_value;
    end else if (w_tick) begin
      if (up_down) begin
        if (r_count == c_max) begin
          w_count_next = auto_reload ? r_shadow : c_zero;
          w_ov_set     = 1'b1;
        end else begin
          w_count_next = r_count + c_one;
        end
      end else begin
        if (r_count == c_zero) begin
          w_count_next = auto_reload ? r_shadow : c_max;
          w_un_set     = 1'b1;
        end else begin
          w_count_next = r_count - c_one;
        end
      end
    end
  end

  // Compare is evaluated against the value the counter is about to take,
  // and only on edges that actually update the counter.
  assign w_cm_set = (load | w_tick) & (w_count_next == compare_value);

  // Flags: a set on the same edge as a clear wins, so no event is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= c_zero;
      r_shadow    <= c_zero;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_compare   <= 1'b0;
    end else begin
      r_count     <= w_count_next;
      if (load) begin
        r_shadow <= start_value;
      end
      r_overflow  <= w_ov_set | (r_overflow  & ~clr_overflow);
      r_underflow <= w_un_set | (r_underflow & ~clr_underflow);
      r_compare   <= w_cm_set | (r_compare   & ~clr_compare);
    end
  end

  assign count         = r_count;
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;
  assign compare_match = r_compare;

endmodule
`default_nettype wire

// File: tb/tb_timer_counter_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_counter_n
// Purpose  : Scoreboard bench for timer_counter_n. Two instances (WIDTH=8 and
//            WIDTH=4) share one stimulus stream. A reference model pushes the
//            expected post-edge state into a queue; a monitor pops it and
//            compares it one time unit after every rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_counter_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_ena, up_down, load, enable, auto_reload;
  logic       clr_overflow, clr_underflow, clr_compare;
  logic [7:0] start_value, compare_value;

  logic [7:0] count8;
  logic       ov8, un8, cm8;
  logic [3:0] count4;
  logic       ov4, un4, cm4;

  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int popped = 0;

  typedef struct {
    int c8; bit o8; bit u8; bit m8;
    int c4; bit o4; bit u4; bit m4;
  } exp_t;
  exp_t sbq[$];

  // Reference model state, index 0 = WIDTH 8, index 1 = WIDTH 4.
  int m_cnt[2], m_sh[2];
  bit m_ov[2], m_un[2], m_cm[2];

  always #5 clk = ~clk;

  timer_counter_n #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .clk_ena(clk_ena), .start_value(start_value),
    .up_down(up_down), .load(load), .enable(enable), .auto_reload(auto_reload),
    .compare_value(compare_value), .clr_overflow(clr_overflow),
    .clr_underflow(clr_underflow), .clr_compare(clr_compare),
    .count(count8), .overflow(ov8), .underflow(un8), .compare_match(cm8)
  );

  timer_counter_n #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .clk_ena(clk_ena), .start_value(start_value[3:0]),
    .up_down(up_down), .load(load), .enable(enable), .auto_reload(auto_reload),
    .compare_value(compare_value[3:0]), .clr_overflow(clr_overflow),
    .clr_underflow(clr_underflow), .clr_compare(clr_compare),
    .count(count4), .overflow(ov4), .underflow(un4), .compare_match(cm4)
  );

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_sh[i] = 0; m_ov[i] = 0; m_un[i] = 0; m_cm[i] = 0;
    end
  endtask

  // One clock edge of the counter rules, in plain integer arithmetic.
  task automatic model_edge(input int i, input int w);
    int  modulus, maxv, sv, cv, nxt;
    bit  ov_set, un_set, cm_set;
    modulus = 1 << w;
    maxv    = modulus - 1;
    sv      = int'(start_value) % modulus;
    cv      = int'(compare_value) % modulus;
    nxt     = m_cnt[i];
    ov_set  = 0; un_set = 0; cm_set = 0;
    if (load) begin
      nxt     = sv;
      m_sh[i] = sv;
      cm_set  = (nxt == cv);
    end else if (enable && clk_ena) begin
      if (up_down) begin
        if (m_cnt[i] == maxv) begin
          nxt = auto_reload ? m_sh[i] : 0;
          ov_set = 1;
        end else nxt = m_cnt[i] + 1;
      end else begin
        if (m_cnt[i] == 0) begin
          nxt = auto_reload ? m_sh[i] : maxv;
          un_set = 1;
        end else nxt = m_cnt[i] - 1;
      end
      cm_set = (nxt == cv);
    end
    m_cnt[i] = nxt;
    m_ov[i]  = ov_set || (m_ov[i] && !clr_overflow);
    m_un[i]  = un_set || (m_un[i] && !clr_underflow);
    m_cm[i]  = cm_set || (m_cm[i] && !clr_compare);
  endtask

  // Called at a falling edge with inputs already applied: predict the next
  // rising edge, queue it, and return at the following falling edge.
  task automatic cyc();
    exp_t e;
    if (!rst_n) model_reset();
    else begin
      model_edge(0, 8);
      model_edge(1, 4);
    end
    e.c8 = m_cnt[0]; e.o8 = m_ov[0]; e.u8 = m_un[0]; e.m8 = m_cm[0];
    e.c4 = m_cnt[1]; e.o4 = m_ov[1]; e.u4 = m_un[1]; e.m4 = m_cm[1];
    sbq.push_back(e);
    pushed++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: the counter presents a new state after every rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      popped++;
      checks++;
      if (int'(count8) !== e.c8 || ov8 !== e.o8 || un8 !== e.u8 || cm8 !== e.m8 ||
          int'(count4) !== e.c4 || ov4 !== e.o4 || un4 !== e.u4 || cm4 !== e.m4) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got w8 %0d/%b%b%b w4 %0d/%b%b%b expected w8 %0d/%b%b%b w4 %0d/%b%b%b",
                 $time, count8, ov8, un8, cm8, count4, ov4, un4, cm4,
                 e.c8, e.o8, e.u8, e.m8, e.c4, e.o4, e.u4, e.m4);
      end
    end
  end

  task automatic idle_inputs();
    clk_ena = 1; up_down = 1; load = 0; enable = 1; auto_reload = 0;
    clr_overflow = 0; clr_underflow = 0; clr_compare = 0;
    start_value = 0; compare_value = 8'd200;
  endtask

  initial begin
    int guard;
    rst_n = 0;
    idle_inputs();
    model_reset();
    @(negedge clk);

    // Reset held for 5 clocks, then release.
    repeat (5) cyc();
    rst_n = 1;
    chk("reset_count", int'(count8), 0);
    chk("reset_flags", {ov8, un8, cm8}, 0);

    // Load 10, one up tick, then count down to zero and underflow.
    load = 1; start_value = 8'd10; cyc();
    load = 0; cyc();
    chk("up_tick_11", int'(count8), 11);
    up_down = 0;
    repeat (11) cyc();
    chk("down_to_0", int'(count8), 0);
    chk("no_underflow_yet", un8, 0);
    cyc();
    chk("down_wrap_255", int'(count8), 255);
    chk("underflow_set", un8, 1);

    // Auto-reload overflow from 250.
    up_down = 1; auto_reload = 1; load = 1; start_value = 8'd250; cyc();
    load = 0;
    repeat (6) cyc();
    chk("reload_250", int'(count8), 250);
    chk("overflow_set", ov8, 1);
    clr_overflow = 1; cyc(); clr_overflow = 0;
    chk("overflow_cleared", ov8, 0);

    // Compare match, then a clear that coincides with a wrap to 5.
    compare_value = 8'd5; auto_reload = 0;
    load = 1; start_value = 0; clr_compare = 1; cyc();
    load = 0; clr_compare = 0;
    repeat (5) cyc();
    chk("cmp_count_5", int'(count8), 5);
    chk("cmp_match_set", cm8, 1);
    auto_reload = 1; load = 1; start_value = 8'd5; cyc();
    load = 0; clr_compare = 1; cyc(); clr_compare = 0;
    chk("cmp_cleared", cm8, 0);
    guard = 0;
    while (m_cnt[0] != 255 && guard < 400) begin cyc(); guard++; end
    chk("reach_255_bound", guard < 400, 1);
    clr_compare = 1; cyc(); clr_compare = 0;
    chk("wrap_to_5", int'(count8), 5);
    chk("set_beats_clear", cm8, 1);

    // clk_ena low holds the count; load beats a coincident tick.
    clk_ena = 0;
    repeat (20) cyc();
    chk("hold_no_tick", int'(count8), 5);
    clk_ena = 1; load = 1; start_value = 8'd77; cyc(); load = 0;
    chk("load_over_tick", int'(count8), 77);

    // WIDTH=4 free-run up from 0: 16 ticks wraps to 0 with overflow.
    rst_n = 0; cyc(); rst_n = 1;
    auto_reload = 0; up_down = 1; compare_value = 8'd200;
    repeat (16) cyc();
    chk("w4_wrap_0", int'(count4), 0);
    chk("w4_overflow", ov4, 1);
    chk("w8_16", int'(count8), 16);
    repeat (3) cyc();
    rst_n = 0;
    #1;
    chk("async_rst_count", int'(count8) + int'(count4), 0);
    chk("async_rst_flags", {ov8, un8, cm8, ov4, un4, cm4}, 0);
    cyc(); rst_n = 1;

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      rst_n         = ($urandom_range(0, 99) != 0);
      load          = ($urandom_range(0, 15) == 0);
      clk_ena       = ($urandom_range(0, 3) != 0);
      enable        = ($urandom_range(0, 7) != 0);
      up_down       = ($urandom_range(0, 1) == 1);
      auto_reload   = ($urandom_range(0, 1) == 1);
      clr_overflow  = ($urandom_range(0, 7) == 0);
      clr_underflow = ($urandom_range(0, 7) == 0);
      clr_compare   = ($urandom_range(0, 7) == 0);
      start_value   = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(240, 255))
                                                 : 8'($urandom_range(0, 15));
      compare_value = 8'($urandom_range(0, 15));
      cyc();
    end
    rst_n = 1;
    idle_inputs();

    guard = 0;
    while (sbq.size() > 0 && guard < 10) begin @(negedge clk); guard++; end
    chk("scoreboard_drained", popped, pushed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
